// File: rtl/sync_fifo_wl_if.sv
// Handshake bundle for sync_fifo_wl: producer/consumer side drives through
// master, the FIFO itself connects through slave.
interface sync_fifo_wl_if #(
  parameter int DATA_WIDTH  = 12,
  parameter int DEPTH_WIDTH = 10
);
  logic                   wr_en;
  logic [DATA_WIDTH-1:0]  wr_data;
  logic                   wr_full;
  logic                   almost_full;
  logic                   rd_en;
  logic [DATA_WIDTH-1:0]  rd_data;
  logic                   rd_empty;
  logic                   almost_empty;
  logic [DEPTH_WIDTH:0]   water_level;
  logic                   overflow;
  logic                   underflow;
  logic                   err_clr;

  modport master (
    output wr_en, wr_data, rd_en, err_clr,
    input  wr_full, almost_full, rd_data, rd_empty, almost_empty,
           water_level, overflow, underflow
  );

  modport slave (
    input  wr_en, wr_data, rd_en, err_clr,
    output wr_full, almost_full, rd_data, rd_empty, almost_empty,
           water_level, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_wl.sv
// Single-clock FIFO with registered flags, water level, almost thresholds and
// sticky error flags. Define FIFO_FWFT_EN for first-word fall-through output.
module sync_fifo_wl #(
  parameter int DATA_WIDTH       = 12,
  parameter int DEPTH_WIDTH      = 10,
  parameter int ALMOST_FULL_NUM  = 1020,
  parameter int ALMOST_EMPTY_NUM = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  sync_fifo_wl_if.slave  bus
);
  localparam int DEPTH = 1 << DEPTH_WIDTH;
  localparam int PW    = DEPTH_WIDTH + 1;
  localparam logic [PW-1:0] LVL_FULL = PW'(DEPTH);
  localparam logic [PW-1:0] LVL_AF   = PW'(ALMOST_FULL_NUM);
  localparam logic [PW-1:0] LVL_AE   = PW'(ALMOST_EMPTY_NUM);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]         level_q, level_d;
  logic                  wr_full_q, wr_full_d;
  logic                  rd_empty_q, rd_empty_d;
  logic                  almost_full_q, almost_full_d;
  logic                  almost_empty_q, almost_empty_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  wr_acc, rd_acc, ram_rd;

  assign wr_acc = bus.wr_en & ~wr_full_q;
  assign rd_acc = bus.rd_en & ~rd_empty_q;

`ifdef FIFO_FWFT_EN
  // Output stage: stage_vld_q means the stage holds a word; rd_empty drops one
  // edge after it is primed from empty, but refills on acknowledge are immediate.
  logic stage_vld_q, stage_vld_d;
  logic ram_has_word;

  assign ram_has_word = (wr_ptr_q != rd_ptr_q);
  assign ram_rd       = ram_has_word & (~stage_vld_q | rd_acc);

  always_ff @(posedge clk) begin
    if (!rst_n) stage_vld_q <= 1'b0;
    else        stage_vld_q <= stage_vld_d;
  end
`else
  assign ram_rd = rd_acc;
`endif

  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(wr_acc);
    rd_ptr_d = rd_ptr_q + PW'(ram_rd);

    level_d = level_q;
    if (wr_acc && !rd_acc)      level_d = level_q + PW'(1);
    else if (!wr_acc && rd_acc) level_d = level_q - PW'(1);

    almost_full_d  = (level_d >= LVL_AF);
    almost_empty_d = (level_d <= LVL_AE);

    // Setting an error wins over a simultaneous clear.
    overflow_d  = (bus.wr_en & wr_full_q)  | (overflow_q  & ~bus.err_clr);
    underflow_d = (bus.rd_en & rd_empty_q) | (underflow_q & ~bus.err_clr);

    rd_data_d = rd_data_q;
    if (ram_rd) rd_data_d = mem[rd_ptr_q[DEPTH_WIDTH-1:0]];

`ifdef FIFO_FWFT_EN
    stage_vld_d = ram_rd | (stage_vld_q & ~rd_acc);
    rd_empty_d  = ~(stage_vld_q & (~rd_acc | ram_rd));
    wr_full_d   = (level_d == LVL_FULL);
`else
    rd_empty_d = (wr_ptr_d == rd_ptr_d);
    wr_full_d  = (wr_ptr_d[DEPTH_WIDTH] != rd_ptr_d[DEPTH_WIDTH]) &&
                 (wr_ptr_d[DEPTH_WIDTH-1:0] == rd_ptr_d[DEPTH_WIDTH-1:0]);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst_n && wr_acc) mem[wr_ptr_q[DEPTH_WIDTH-1:0]] <= bus.wr_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      level_q        <= '0;
      wr_full_q      <= 1'b0;
      rd_empty_q     <= 1'b1;
      almost_full_q  <= 1'b0;
      almost_empty_q <= 1'b1;
      overflow_q     <= 1'b0;
      underflow_q    <= 1'b0;
      rd_data_q      <= '0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      level_q        <= level_d;
      wr_full_q      <= wr_full_d;
      rd_empty_q     <= rd_empty_d;
      almost_full_q  <= almost_full_d;
      almost_empty_q <= almost_empty_d;
      overflow_q     <= overflow_d;
      underflow_q    <= underflow_d;
      rd_data_q      <= rd_data_d;
    end
  end

  assign bus.wr_full      = wr_full_q;
  assign bus.almost_full  = almost_full_q;
  assign bus.rd_empty     = rd_empty_q;
  assign bus.almost_empty = almost_empty_q;
  assign bus.water_level  = level_q;
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;
  assign bus.rd_data      = rd_data_q;
endmodule
